// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate data cache, 4-byte blocks.
// Ports: CLK/RESET, cpu READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT,
// memory MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA/MEM_READDATA/MEM_BUSYWAIT.
// Optional DCACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT outputs.
module dcache #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [7:0]        WRITEDATA,
  output logic [7:0]        READDATA,
  output logic              BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-3:0] MEM_ADDRESS,
  output logic [31:0]       MEM_WRITEDATA,
  input  logic [31:0]       MEM_READDATA,
  input  logic              MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       HIT_COUNT,
  output logic [15:0]       MISS_COUNT
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_t;

  state_t state, next;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         off;
  logic [31:0]        line;
  logic               hit;
  logic               req;
  logic               wr_hit;

  assign idx    = ADDRESS[INDEX_W+1:2];
  assign tag    = ADDRESS[ADDR_W-1:INDEX_W+2];
  assign off    = ADDRESS[1:0];
  assign line   = data[idx];
  assign hit    = valid[idx] && (tags[idx] == tag);
  assign req    = READ | WRITE;
  assign wr_hit = (state == IDLE) && WRITE && hit;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next          = state;
    BUSYWAIT      = 1'b0;
    READDATA      = 8'h00;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = 32'h0;
    unique case (state)
      IDLE: begin
        // an invalid line reads as zero so reset shows a clean bus
        if (valid[idx])
          READDATA = line[{off, 3'b000} +: 8];
        if (req && !hit) begin
          BUSYWAIT = 1'b1;
          next     = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tags[idx], idx};
        MEM_WRITEDATA = line;
        if (!MEM_BUSYWAIT) next = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag, idx};
        if (!MEM_BUSYWAIT) next = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == UPDATE) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // payload arrays need no reset; valid bits guard them
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state == UPDATE) begin
        data[idx] <= MEM_READDATA;
        tags[idx] <= tag;
      end else if (wr_hit) begin
        data[idx][{off, 3'b000} +: 8] <= WRITEDATA;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic refill;
  logic hit_done;
  logic miss_start;

  // the access that resumes right after a refill is part of its miss
  assign hit_done   = (state == IDLE) && req && hit && !refill;
  assign miss_start = (state == IDLE) && (next != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      refill     <= 1'b0;
      HIT_COUNT  <= 16'h0;
      MISS_COUNT <= 16'h0;
    end else begin
      if (state == UPDATE)    refill <= 1'b1;
      else if (state == IDLE) refill <= 1'b0;
      if (hit_done && (HIT_COUNT != 16'hFFFF))
        HIT_COUNT <= HIT_COUNT + 16'd1;
      if (miss_start && (MISS_COUNT != 16'hFFFF))
        MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: flat-memory reference, read and write-back scoreboards.
// Memory model holds MEM_BUSYWAIT high 4 cycles per request.
module tb_dcache;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT;
  logic [15:0] MISS_COUNT;
`endif

  dcache dut (
    .CLK(CLK),
    .RESET(RESET),
    .READ(READ),
    .WRITE(WRITE),
    .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA),
    .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT(HIT_COUNT),
    .MISS_COUNT(MISS_COUNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int compared = 0;
  int mismatched = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // memory model
  logic [31:0] mem [64];
  logic [2:0]  cnt;
  logic        done;
  logic        last_rd;
  logic        inited = 1'b0;
  logic        mreq;

  assign mreq = MEM_READ | MEM_WRITE;
  assign MEM_BUSYWAIT = mreq && !(done && (last_rd == MEM_READ));

  always @(posedge CLK) begin
    if (!inited) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      inited = 1'b1;
      cnt <= 3'd0;
      done <= 1'b0;
      last_rd <= 1'b0;
      MEM_READDATA <= 32'h0;
    end else if (!mreq) begin
      cnt <= 3'd0;
      done <= 1'b0;
    end else if (done && (last_rd == MEM_READ)) begin
      cnt <= cnt;
    end else if (done) begin
      done <= 1'b0;
      cnt <= 3'd1;
    end else if (cnt == 3'd3) begin
      done <= 1'b1;
      last_rd <= MEM_READ;
      if (MEM_READ) MEM_READDATA <= mem[MEM_ADDRESS];
      else mem[MEM_ADDRESS] = MEM_WRITEDATA;
    end else begin
      cnt <= cnt + 3'd1;
    end
  end

  // reference: what each byte should read as, plus line residency
  logic [7:0] truth [256];
  logic       rv [8];
  logic       rdty [8];
  logic [2:0] rt [8];
  int         ref_hits;
  int         ref_misses;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t        wb_q [$];
  logic [7:0] rd_q [$];

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      truth[i] = mem[a[7:2]][{a[1:0], 3'b000} +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      rv[i] = 1'b0;
      rdty[i] = 1'b0;
      rt[i] = 3'd0;
    end
    ref_hits = 0;
    ref_misses = 0;
    wb_q.delete();
    rd_q.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    READ = 1'b0;
    WRITE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    ref_reset();
  endtask

  // monitor: pops expectations whenever the DUT presents a result
  logic wb_prev = 1'b0;
  always @(negedge CLK) begin
    if (RESET) begin
      wb_prev = 1'b0;
    end else begin
      if (mreq)
        chk("mem_rw_exclusive", 32'(MEM_READ & MEM_WRITE), 32'd0);
      if (MEM_READ)
        chk("fetch_addr", 32'(MEM_ADDRESS), 32'(ADDRESS[7:2]));
      if (MEM_WRITE && !wb_prev) begin
        if (wb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL wb_unexpected: got addr %h expected none",
                   MEM_ADDRESS);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          chk("wb_addr", 32'(MEM_ADDRESS), 32'(e.addr));
          chk("wb_data", MEM_WRITEDATA, e.data);
        end
      end
      wb_prev = MEM_WRITE;
      if (READ && !WRITE && !BUSYWAIT) begin
        if (rd_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rd_unexpected: got %h expected none", READDATA);
        end else begin
          logic [7:0] e;
          e = rd_q.pop_front();
          chk("readdata", 32'(READDATA), 32'(e));
        end
      end
    end
  end

  task automatic access(input bit wr, input bit both,
                        input logic [7:0] a, input logic [7:0] d);
    logic [2:0] idx;
    logic [2:0] tg;
    logic       hit;
    int         exp_st;
    int         st;
    bit         fin;
    idx = a[4:2];
    tg = a[7:5];
    hit = rv[idx] && (rt[idx] == tg);
    exp_st = 0;
    if (!hit) begin
      exp_st = 7;
      if (rv[idx] && rdty[idx]) begin
        wb_t w;
        logic [5:0] vb;
        vb = {rt[idx], idx};
        w.addr = vb;
        w.data = {truth[{vb, 2'd3}], truth[{vb, 2'd2}],
                  truth[{vb, 2'd1}], truth[{vb, 2'd0}]};
        wb_q.push_back(w);
        exp_st = 12;
      end
      rv[idx] = 1'b1;
      rt[idx] = tg;
      rdty[idx] = 1'b0;
      ref_misses++;
    end else begin
      ref_hits++;
    end
    if (wr) begin
      truth[a] = d;
      rdty[idx] = 1'b1;
    end else begin
      rd_q.push_back(truth[a]);
    end
    READ = !wr || both;
    WRITE = wr;
    ADDRESS = a;
    WRITEDATA = d;
    st = 0;
    fin = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (i == 0) chk("first_busywait", 32'(BUSYWAIT), 32'(!hit));
      if (!BUSYWAIT) begin
        fin = 1'b1;
        break;
      end
      st++;
    end
    if (!fin) begin
      compared++;
      mismatched++;
      $display("FAIL access_timeout: got busy at %h expected done", a);
    end else begin
      chk("stall_cycles", 32'(st), 32'(exp_st));
    end
    @(posedge CLK);
    #1;
    READ = 1'b0;
    WRITE = 1'b0;
  endtask

  initial begin
    bit fin;
    RESET = 1'b1;
    READ = 1'b0;
    WRITE = 1'b0;
    ADDRESS = 8'h05;
    WRITEDATA = 8'h00;
    do_reset();

    @(negedge CLK);
    chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_readdata", 32'(READDATA), 32'd0);
    @(posedge CLK);
    #1;

    access(0, 0, 8'h05, 8'h00);
    access(1, 0, 8'h05, 8'hAB);
    access(0, 0, 8'h05, 8'h00);
    access(0, 0, 8'h25, 8'h00);
`ifdef DCACHE_STATS_EN
    chk("stats_miss_seq", 32'(MISS_COUNT), 32'd2);
    chk("stats_hit_seq", 32'(HIT_COUNT), 32'd2);
`endif
    access(0, 0, 8'h45, 8'h00);

    READ = 1'b1;
    ADDRESS = 8'h65;
    fin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (MEM_READ) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      compared++;
      mismatched++;
      $display("FAIL fetch_timeout: got no MEM_READ expected MEM_READ");
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    READ = 1'b0;
    @(posedge CLK);
    #1;
    chk("midrst_mem_read", 32'(MEM_READ), 32'd0);
    chk("midrst_busywait", 32'(BUSYWAIT), 32'd0);
    RESET = 1'b0;
    ref_reset();
    access(0, 0, 8'h05, 8'h00);

    for (int n = 0; n < 400; n++) begin
      bit wr;
      bit both;
      logic [2:0] tg;
      logic [4:0] lo;
      wr = ($urandom_range(0, 9) < 4);
      both = wr && ($urandom_range(0, 7) == 0);
      tg = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) tg = 3'($urandom_range(4, 7));
      lo = 5'($urandom);
      access(wr, both, {tg, lo}, 8'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        @(negedge CLK);
        chk("idle_busywait", 32'(BUSYWAIT), 32'd0);
        @(posedge CLK);
        #1;
      end
    end

`ifdef DCACHE_STATS_EN
    chk("stats_hits", 32'(HIT_COUNT), 32'(ref_hits));
    chk("stats_misses", 32'(MISS_COUNT), 32'(ref_misses));
`endif
    @(negedge CLK);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
